// File: rtl/serial_adder_if.sv
// Handshake bundle for the bit-serial adder: operand request channel and result channel.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             done_valid;
  logic             done_ready;

  modport slave (
    input  start_valid, a_in, b_in, cin, done_ready,
    output start_ready, sum_out, cout, done_valid
  );

  modport master (
    output start_valid, a_in, b_in, cin, done_ready,
    input  start_ready, sum_out, cout, done_valid
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell (two half adders) iterated LSB first,
// carry held in a register between cycles; valid/ready on operands and result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             c1, s1, c2, s2;
  logic             carry_next;
  logic [WIDTH-1:0] sum_next;

  // Returns {carry, sum} of one half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  always_comb begin
    {c1, s1}   = half_add(a_sr[0], b_sr[0]);
    {c2, s2}   = half_add(s1, carry);
    carry_next = c1 | c2;
    // New sum bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
    sum_next            = sum_sr >> 1;
    sum_next[WIDTH-1]   = s2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_valid) begin
            a_sr   <= bus.a_in;
            b_sr   <= bus.b_in;
            carry  <= bus.cin;
            sum_sr <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          sum_sr <= sum_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.done_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == S_IDLE);
  assign bus.done_valid  = (state == S_DONE);
  assign bus.sum_out     = sum_sr;
  assign bus.cout        = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios at WIDTH=8 and randomized streaming
// at WIDTH=8 and WIDTH=1 against an arithmetic reference (a + b + cin).
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus8.start_valid = 1'b0; bus8.done_ready = 1'b0;
    bus8.a_in = '0; bus8.b_in = '0; bus8.cin = 1'b0;
    bus1.start_valid = 1'b0; bus1.done_ready = 1'b0;
    bus1.a_in = '0; bus1.b_in = '0; bus1.cin = 1'b0;
  endtask

  // Runs one WIDTH=8 transaction and reports what was observed; callers judge it.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input bit scramble, output logic [7:0] s, output logic co,
                        output int lat, output bit ready_bad);
    int guard = 0;
    ready_bad = 1'b0;
    lat = -1;
    while (!bus8.start_ready && guard < 50) begin tick; guard++; end
    bus8.a_in = a; bus8.b_in = b; bus8.cin = c; bus8.start_valid = 1'b1;
    tick;
    bus8.start_valid = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      if (bus8.start_ready) ready_bad = 1'b1;
      if (scramble) begin
        bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.cin = 1'($urandom);
      end
      tick;
      if (bus8.done_valid) begin lat = k; break; end
    end
    if (bus8.start_ready) ready_bad = 1'b1;
    s  = bus8.sum_out;
    co = bus8.cout;
    if (lat > 0) begin bus8.done_ready = 1'b1; tick; bus8.done_ready = 1'b0; end
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick; tick;
    checks += 4;
    if (bus8.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b want 1", bus8.start_ready); end
    if (bus8.done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid: got %b want 0", bus8.done_valid); end
    if (bus8.sum_out !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", bus8.sum_out); end
    if (bus8.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus8.cout); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    logic [7:0] s; logic co; int lat; bit rb;
    do_op8(8'h00, 8'h00, 1'b0, 1'b0, s, co, lat, rb);
    checks += 6;
    if (lat !== 8) begin errors++; $display("FAIL zero_latency: got %0d want 8", lat); end
    if (s !== 8'h00) begin errors++; $display("FAIL zero_sum: got %h want 00", s); end
    if (co !== 1'b0) begin errors++; $display("FAIL zero_cout: got %b want 0", co); end
    if (rb !== 1'b0) begin errors++; $display("FAIL zero_busy_ready: got %b want 0", rb); end
    if (bus8.start_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_after: got %b want 1", bus8.start_ready); end
    if (bus8.done_valid !== 1'b0) begin errors++; $display("FAIL zero_done_after: got %b want 0", bus8.done_valid); end
  endtask

  task automatic test_wrap;
    logic [7:0] s; logic co; int lat; bit rb;
    do_op8(8'hFF, 8'h01, 1'b0, 1'b0, s, co, lat, rb);
    checks += 2;
    if ({co, s} !== 9'h100) begin errors++; $display("FAIL wrap_ff_01: got %h want 100", {co, s}); end
    if (lat !== 8) begin errors++; $display("FAIL wrap_latency: got %0d want 8", lat); end
    do_op8(8'hFF, 8'hFF, 1'b1, 1'b0, s, co, lat, rb);
    checks += 1;
    if ({co, s} !== 9'h1FF) begin errors++; $display("FAIL wrap_ff_ff_1: got %h want 1ff", {co, s}); end
  endtask

  task automatic test_ignore_inputs;
    logic [7:0] s; logic co; int lat; bit rb;
    do_op8(8'h5A, 8'h3C, 1'b1, 1'b1, s, co, lat, rb);
    checks += 2;
    if ({co, s} !== 9'h097) begin errors++; $display("FAIL scramble_result: got %h want 097", {co, s}); end
    if (lat !== 8) begin errors++; $display("FAIL scramble_latency: got %0d want 8", lat); end
  endtask

  task automatic test_backpressure;
    int guard = 0;
    bus8.a_in = 8'h12; bus8.b_in = 8'h34; bus8.cin = 1'b0; bus8.start_valid = 1'b1;
    tick;
    bus8.start_valid = 1'b0;
    while (!bus8.done_valid && guard < 50) begin tick; guard++; end
    checks += 1;
    if (bus8.done_valid !== 1'b1) begin errors++; $display("FAIL bp_done_timeout: got %b want 1", bus8.done_valid); end
    for (int i = 0; i < 5; i++) begin
      bus8.start_valid = 1'(i % 2 == 0);
      bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.cin = 1'($urandom);
      tick;
      checks += 3;
      if (bus8.done_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", bus8.done_valid); end
      if ({bus8.cout, bus8.sum_out} !== 9'h046) begin errors++; $display("FAIL bp_hold_result: got %h want 046", {bus8.cout, bus8.sum_out}); end
      if (bus8.start_ready !== 1'b0) begin errors++; $display("FAIL bp_no_accept: got %b want 0", bus8.start_ready); end
    end
    bus8.start_valid = 1'b0;
    bus8.done_ready = 1'b1;
    tick;
    bus8.done_ready = 1'b0;
    checks += 2;
    if (bus8.start_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus8.start_ready); end
    if (bus8.done_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus8.done_valid); end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] s; logic co; int lat; bit rb;
    bus8.a_in = 8'hAA; bus8.b_in = 8'h55; bus8.cin = 1'b0; bus8.start_valid = 1'b1;
    tick;
    bus8.start_valid = 1'b0;
    repeat (4) tick;
    checks += 1;
    if (bus8.sum_out !== 8'hF0) begin errors++; $display("FAIL midrun_partial: got %h want f0", bus8.sum_out); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus8.start_ready !== 1'b1) begin errors++; $display("FAIL abort_start_ready: got %b want 1", bus8.start_ready); end
    if (bus8.done_valid !== 1'b0) begin errors++; $display("FAIL abort_done_valid: got %b want 0", bus8.done_valid); end
    if (bus8.sum_out !== 8'h00) begin errors++; $display("FAIL abort_sum: got %h want 00", bus8.sum_out); end
    if (bus8.cout !== 1'b0) begin errors++; $display("FAIL abort_cout: got %b want 0", bus8.cout); end
    tick;
    rst_n = 1'b1;
    do_op8(8'h01, 8'h01, 1'b0, 1'b0, s, co, lat, rb);
    checks += 2;
    if ({co, s} !== 9'h002) begin errors++; $display("FAIL post_reset_result: got %h want 002", {co, s}); end
    if (lat !== 8) begin errors++; $display("FAIL post_reset_latency: got %0d want 8", lat); end
  endtask

  task automatic test_back_to_back_w8;
    logic [8:0] expq[$];
    int accq[$];
    int last_acc = -1, got = 0, accepted = 0, limit, acc, w;
    logic [8:0] e;
    w = 8;
    bus8.done_ready = 1'b1; bus8.start_valid = 1'b1;
    bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.cin = 1'($urandom);
    limit = cyc + 200 * (w + 2) + 100;
    while (got < 200 && cyc < limit) begin
      if (bus8.start_ready && bus8.start_valid) begin
        expq.push_back(9'(bus8.a_in) + 9'(bus8.b_in) + 9'(bus8.cin));
        accq.push_back(cyc);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != w + 2) begin errors++; $display("FAIL w8_spacing: got %0d want %0d", cyc - last_acc, w + 2); end
        end
        last_acc = cyc; accepted++;
      end
      tick;
      bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.cin = 1'($urandom);
      if (accepted >= 200) bus8.start_valid = 1'b0;
      if (bus8.done_valid) begin
        checks += 2;
        if (expq.size() == 0) begin
          errors += 2; $display("FAIL w8_unexpected_result: got %h want none", {bus8.cout, bus8.sum_out});
        end else begin
          e = expq.pop_front(); acc = accq.pop_front();
          if ({bus8.cout, bus8.sum_out} !== e) begin errors++; $display("FAIL w8_result: got %h want %h", {bus8.cout, bus8.sum_out}, e); end
          if (cyc - acc - 1 != w) begin errors++; $display("FAIL w8_latency: got %0d want %0d", cyc - acc - 1, w); end
        end
        got++;
      end
    end
    checks++;
    if (got != 200) begin errors++; $display("FAIL w8_result_count: got %0d want 200", got); end
    bus8.start_valid = 1'b0; bus8.done_ready = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back_w1;
    logic [1:0] expq[$];
    int accq[$];
    int last_acc = -1, got = 0, accepted = 0, limit, acc, w;
    logic [1:0] e;
    w = 1;
    bus1.done_ready = 1'b1; bus1.start_valid = 1'b1;
    bus1.a_in = 1'($urandom); bus1.b_in = 1'($urandom); bus1.cin = 1'($urandom);
    limit = cyc + 200 * (w + 2) + 100;
    while (got < 200 && cyc < limit) begin
      if (bus1.start_ready && bus1.start_valid) begin
        expq.push_back(2'(bus1.a_in) + 2'(bus1.b_in) + 2'(bus1.cin));
        accq.push_back(cyc);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != w + 2) begin errors++; $display("FAIL w1_spacing: got %0d want %0d", cyc - last_acc, w + 2); end
        end
        last_acc = cyc; accepted++;
      end
      tick;
      bus1.a_in = 1'($urandom); bus1.b_in = 1'($urandom); bus1.cin = 1'($urandom);
      if (accepted >= 200) bus1.start_valid = 1'b0;
      if (bus1.done_valid) begin
        checks += 2;
        if (expq.size() == 0) begin
          errors += 2; $display("FAIL w1_unexpected_result: got %b want none", {bus1.cout, bus1.sum_out});
        end else begin
          e = expq.pop_front(); acc = accq.pop_front();
          if ({bus1.cout, bus1.sum_out} !== e) begin errors++; $display("FAIL w1_result: got %b want %b", {bus1.cout, bus1.sum_out}, e); end
          if (cyc - acc - 1 != w) begin errors++; $display("FAIL w1_latency: got %0d want %0d", cyc - acc - 1, w); end
        end
        got++;
      end
    end
    checks++;
    if (got != 200) begin errors++; $display("FAIL w1_result_count: got %0d want 200", got); end
    bus1.start_valid = 1'b0; bus1.done_ready = 1'b0;
    tick;
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_zero();
    test_wrap();
    test_ignore_inputs();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back_w8();
    test_back_to_back_w1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
